bm_dag1_log_drv: RTL

- Self-contained stimulus driver and response compactor for the dag1 logic micro-benchmark port set.
- Drives `a_in`, `b_in`, `c_in` and `d_in` from an 8-bit LFSR, one vector per cycle.
- Compacts the returned `out0`/`out1` into an 8-bit MISR signature.
- Sits on the opposite side of the benchmark's port interface, so the benchmark can run standalone in synthesis/simulation regressions.

---
 rtl/bm_dag1_log_drv_pkg.sv | 30 +++
 rtl/bm_misr8.sv | 49 ++++
 rtl/bm_dag1_log_drv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bm_dag1_log_drv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bm_dag1_log_drv_pkg                                            |
// | Purpose : Shared definitions for the dag1 logic benchmark driver:        |
// |           FSM state encoding, LFSR/MISR tap masks, default seed and the  |
// |           tap-parity helper used by both shift registers.                |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bm_dag1_log_drv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Taps at bits 7,5,4,3 (x^8 + x^6 + x^5 + x^4 + 1).
   localparam logic [7:0] c_lfsr_taps  = 8'hB8;
   localparam logic [7:0] c_misr_taps  = 8'hB8;
   localparam logic [7:0] c_default_seed = 8'hA5;

   // Feedback bit: XOR of the tapped positions.
   function automatic logic tap_parity(input logic [7:0] val, input logic [7:0] taps);
      return ^(val & taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bm_misr8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bm_misr8                                                       |
// | Purpose : 8-bit multiple-input signature register. Shifts left with     |
// |           tap feedback into bit 0 and XORs in the data word each enabled |
// |           cycle. Clear has priority over enable.                         |
// | Ports   : clock   in  1  rising-edge clock                               |
// |           resetn  in  1  synchronous active-low reset                    |
// |           clear   in  1  zero the signature                              |
// |           enable  in  1  compact data this cycle                         |
// |           data    in  8  response word                                   |
// |           sig     out 8  current signature                               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bm_misr8
   import bm_dag1_log_drv_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] data,
   output logic [7:0] sig
);

   logic [7:0] sig_q;
   logic [7:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = 8'h00;
      end else if (enable) begin
         sig_d = {sig_q[6:0], tap_parity(sig_q, c_misr_taps)} ^ data;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sig_q <= 8'h00;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/bm_dag1_log_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bm_dag1_log_drv                                                |
// | Purpose : Standalone stimulus driver / response compactor for the dag1   |
// |           logic benchmark. An 8-bit LFSR supplies one vector per cycle   |
// |           for LEN cycles, LAT drain cycles follow, and out0/out1 are     |
// |           folded into an 8-bit MISR signature.                           |
// | Config  : `define BM_DRV_GOLDEN_CHECK_EN builds the golden comparator    |
// |           driving pass; otherwise pass is tied 0.                        |
// | Ports   : clock      in  1     rising-edge clock                         |
// |           resetn     in  1     synchronous active-low reset              |
// |           start      in  1     begin a run (sampled only in IDLE)        |
// |           a_in/b_in  out BITS  vector fields a/b                         |
// |           c_in/d_in  out 1     vector fields c/d                         |
// |           out0       in  BITS  benchmark response                        |
// |           out1       in  1     benchmark response                        |
// |           busy       out 1     high in RUN and DRAIN                     |
// |           done       out 1     one-cycle end-of-run pulse                |
// |           signature  out 8     MISR value, held after done               |
// |           pass       out 1     golden-compare result                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bm_dag1_log_drv
   import bm_dag1_log_drv_pkg::*;
#(
   parameter int         BITS   = 2,
   parameter int         LEN    = 16,
   parameter int         LAT    = 2,
   parameter logic [7:0] SEED   = c_default_seed,
   parameter logic [7:0] GOLDEN = 8'h00
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            start,
   output logic [BITS-1:0] a_in,
   output logic [BITS-1:0] b_in,
   output logic            c_in,
   output logic            d_in,
   input  logic [BITS-1:0] out0,
   input  logic            out1,
   output logic            busy,
   output logic            done,
   output logic [7:0]      signature,
   output logic            pass
);

   generate
      if ((BITS < 1) || (BITS > 3) || (LEN < 1) || (LEN > 255) ||
          (LAT < 0) || (LAT > 15) || (SEED == 8'h00)) begin : g_param_check
         $error("bm_dag1_log_drv: parameter out of legal range");
      end
   endgenerate

   localparam logic [7:0] c_len_last = 8'(LEN - 1);
   localparam logic [3:0] c_lat_last = 4'(LAT - 1);

   state_e     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] vcnt_q, vcnt_d;
   logic [3:0] dcnt_q, dcnt_d;

   logic       w_start_run;
   logic       w_in_run;
   logic       w_compact;
   logic [7:0] w_misr_data;

   assign w_start_run = (state_q == ST_IDLE) && start;
   assign w_in_run    = (state_q == ST_RUN);
   assign w_compact   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      vcnt_d  = vcnt_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               lfsr_d  = SEED;
               vcnt_d  = 8'h00;
            end
         end
         ST_RUN: begin
            lfsr_d = {lfsr_q[6:0], tap_parity(lfsr_q, c_lfsr_taps)};
            vcnt_d = vcnt_q + 8'h01;
            if (vcnt_q == c_len_last) begin
               dcnt_d  = 4'h0;
               state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            dcnt_d = dcnt_q + 4'h1;
            if (dcnt_q == c_lat_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         lfsr_q  <= 8'h00;
         vcnt_q  <= 8'h00;
         dcnt_q  <= 4'h0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         vcnt_q  <= vcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Vectors come straight off the LFSR so the first one appears the cycle
   // after start; outside RUN the benchmark sees all-zero inputs.
   assign a_in = w_in_run ? lfsr_q[BITS-1:0]      : '0;
   assign b_in = w_in_run ? lfsr_q[2*BITS-1:BITS] : '0;
   assign c_in = w_in_run ? lfsr_q[6]             : 1'b0;
   assign d_in = w_in_run ? lfsr_q[7]             : 1'b0;

   assign busy = w_compact;
   assign done = (state_q == ST_DONE);

   assign w_misr_data = {{(7 - BITS){1'b0}}, out0, out1};

   bm_misr8 u_misr (
      .clock  (clock),
      .resetn (resetn),
      .clear  (w_start_run),
      .enable (w_compact),
      .data   (w_misr_data),
      .sig    (signature)
   );

`ifdef BM_DRV_GOLDEN_CHECK_EN
   logic pass_q;

   // The signature is final during DONE; latch the compare there and hold
   // it until the next run begins.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pass_q <= 1'b0;
      end else if (w_start_run) begin
         pass_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
         pass_q <= (signature == GOLDEN);
      end
   end

   assign pass = pass_q;
`else
   logic w_golden_unused;
   assign w_golden_unused = ^GOLDEN;
   assign pass = 1'b0;
`endif

endmodule
`default_nettype wire
